// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory bus arbiter: FSM state
// encodings, grant encodings and the grant-selection rule.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IBUS  = 3'd1,
        DBUS  = 3'd2,
        IRESP = 3'd3,
        DRESP = 3'd4
    } arbState_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    // Chooses the winner when at least one requester is pending.
    function automatic grant_t pickGrant(input logic iReq, input logic dReq,
                                         input logic dataPrio, input grant_t lastGrant);
        if (iReq && dReq) begin
            if (dataPrio) return GNT_D;
            return (lastGrant == GNT_I) ? GNT_D : GNT_I;
        end
        if (dReq) return GNT_D;
        return GNT_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory bus around the
// arbiter. master = arbiter view, slave = pipeline/memory environment view.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_done;
    logic          i_stall;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          d_stall;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          bus_err;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
               mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
               mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port memory bus between the fetch (I) and mem-stage (D)
// ports. One transaction at a time: grant in IDLE, hold the bus until ack
// or timeout, pulse done for one cycle, then return to IDLE.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int DATA_PRIO = 1,
    parameter int TIMEOUT   = 16
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.master bus
);

    // A zero TIMEOUT disables the watchdog; keep the counter at least 1 bit wide.
    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit            TO_EN    = (TIMEOUT != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arbState_t     state, nextState;
    grant_t        lastGrant;
    logic [CW-1:0] toCnt;

    logic          grantI, grantD;
    logic          ackTake, toFire;

    logic          memReq, memWe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata;
    logic [DW-1:0] iRdata, dRdata;
    logic          busErr;

    // Next-state and per-cycle control decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        nextState = state;
        grantI    = 1'b0;
        grantD    = 1'b0;
        ackTake   = 1'b0;
        toFire    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    if (pickGrant(bus.i_req, bus.d_req, DATA_PRIO != 0, lastGrant) == GNT_D) begin
                        grantD    = 1'b1;
                        nextState = DBUS;
                    end else begin
                        grantI    = 1'b1;
                        nextState = IBUS;
                    end
                end
            end
            IBUS, DBUS: begin
                // An ack in the last allowed cycle beats the timeout.
                if (bus.mem_ack) begin
                    ackTake   = 1'b1;
                    nextState = (state == IBUS) ? IRESP : DRESP;
                end else if (TO_EN && toCnt == CNT_LAST) begin
                    toFire    = 1'b1;
                    nextState = (state == IBUS) ? IRESP : DRESP;
                end
            end
            IRESP, DRESP: nextState = IDLE;
            default:      nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    // Remember the last winner for round-robin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        lastGrant <= GNT_I;
        else if (grantI) lastGrant <= GNT_I;
        else if (grantD) lastGrant <= GNT_D;
    end

    // Timeout counter: cleared at grant, counts ack-less bus cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            toCnt <= '0;
        else if (grantI || grantD)
            toCnt <= '0;
        else if ((state == IBUS || state == DBUS) && !ackTake && !toFire)
            toCnt <= toCnt + CW'(1);
    end

    // Bus registers: loaded at grant, held stable until ack or timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
        end else if (grantI) begin
            memReq   <= 1'b1;
            memWe    <= 1'b0;
            memAddr  <= bus.i_addr;
        end else if (grantD) begin
            memReq   <= 1'b1;
            memWe    <= bus.d_we;
            memAddr  <= bus.d_addr;
            memWdata <= bus.d_wdata;
        end else if (ackTake || toFire) begin
            memReq   <= 1'b0;
        end
    end

    // Fetched-instruction holding register; a timeout returns 0 (a NOP).
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the held read-data registers are reset as well, so the pipeline sees 0 rather than X after reset.
        if (!rst)
            iRdata <= '0;
        else if (state == IBUS && ackTake)
            iRdata <= bus.mem_rdata;
        else if (state == IBUS && toFire)
            iRdata <= '0;
    end

    // Load-data holding register; writes never touch it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            dRdata <= '0;
        else if (state == DBUS && !memWe && ackTake)
            dRdata <= bus.mem_rdata;
        else if (state == DBUS && !memWe && toFire)
            dRdata <= '0;
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        busErr <= 1'b0;
        else if (toFire) busErr <= 1'b1;
    end

    assign bus.mem_req   = memReq;
    assign bus.mem_we    = memWe;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;
    assign bus.i_rdata   = iRdata;
    assign bus.d_rdata   = dRdata;
    assign bus.bus_err   = busErr;
    assign bus.i_done    = (state == IRESP);
    assign bus.d_done    = (state == DRESP);
    // Stalls depend only on state and request, never on mem_ack.
    assign bus.i_stall   = bus.i_req & (state != IRESP);
    assign bus.d_stall   = bus.d_req & (state != DRESP);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance A (data priority, TIMEOUT=4) runs a vector
// table plus priority/timeout/reset sequences; instance B (round-robin,
// TIMEOUT=16) runs the alternating-grant and dropped-request sequences.
// Read data seen at each done pulse is checked against a scoreboard queue.
module tb_mem_arbiter;

    typedef struct {
        logic        isD;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ackDelay;
        logic [31:0] rdata;
        logic [31:0] expRdata;
    } vec_t;

    typedef struct packed {
        logic        isD;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rstA, rstB;
    int   checks = 0;
    int   errors = 0;
    exp_t qA[$];
    exp_t qB[$];

    mem_arbiter_if #(.AW(32), .DW(32)) ifA ();
    mem_arbiter_if #(.AW(32), .DW(32)) ifB ();

    mem_arbiter #(.AW(32), .DW(32), .DATA_PRIO(1), .TIMEOUT(4))  dutA (.clk(clk), .rst(rstA), .bus(ifA));
    mem_arbiter #(.AW(32), .DW(32), .DATA_PRIO(0), .TIMEOUT(16)) dutB (.clk(clk), .rst(rstB), .bus(ifB));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for instance A: compare held read data at each done pulse.
    always @(negedge clk) begin
        if (ifA.i_done || ifA.d_done) begin
            if (qA.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL A_unexpected_done: i_done=%b d_done=%b with empty queue", ifA.i_done, ifA.d_done);
            end else begin
                exp_t e;
                e = qA.pop_front();
                check("A_done_port", {31'b0, ifA.d_done}, {31'b0, e.isD});
                check("A_rdata", e.isD ? ifA.d_rdata : ifA.i_rdata, e.data);
            end
        end
    end

    // Scoreboard for instance B.
    always @(negedge clk) begin
        if (ifB.i_done || ifB.d_done) begin
            if (qB.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL B_unexpected_done: i_done=%b d_done=%b with empty queue", ifB.i_done, ifB.d_done);
            end else begin
                exp_t e;
                e = qB.pop_front();
                check("B_done_port", {31'b0, ifB.d_done}, {31'b0, e.isD});
                check("B_rdata", e.isD ? ifB.d_rdata : ifB.i_rdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        int   hi;
        logic isD;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         2, 32'h2008_0005, 32'h2008_0005};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         0, 32'hCAFE_0001, 32'hCAFE_0001};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1, 32'h5555_5555, 32'hCAFE_0001};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         3, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,         2, 32'h0000_00A5, 32'h0000_00A5};

        {ifA.i_req, ifA.d_req, ifA.d_we, ifA.mem_ack} = '0;
        {ifA.i_addr, ifA.d_addr, ifA.d_wdata, ifA.mem_rdata} = '0;
        {ifB.i_req, ifB.d_req, ifB.d_we, ifB.mem_ack} = '0;
        {ifB.i_addr, ifB.d_addr, ifB.d_wdata, ifB.mem_rdata} = '0;
        rstA = 1'b0;
        rstB = 1'b0;
        step();
        step();

        // Reset state
        check("rstA_mem_req",  ifA.mem_req,  0);
        check("rstA_mem_we",   ifA.mem_we,   0);
        check("rstA_mem_addr", ifA.mem_addr, 0);
        check("rstA_rdata",    ifA.i_rdata | ifA.d_rdata, 0);
        check("rstA_done",     {ifA.i_done, ifA.d_done}, 0);
        check("rstA_bus_err",  ifA.bus_err,  0);
        check("rstB_mem_req",  ifB.mem_req,  0);
        check("rstB_bus_err",  ifB.bus_err,  0);
        rstA = 1'b1;
        rstB = 1'b1;
        step();

        // Table: single transactions on A
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].isD) begin
                ifA.d_req = 1'b1; ifA.d_we = vecs[i].we;
                ifA.d_addr = vecs[i].addr; ifA.d_wdata = vecs[i].wdata;
            end else begin
                ifA.i_req = 1'b1; ifA.i_addr = vecs[i].addr;
            end
            #1;
            check($sformatf("v%0d_stall_idle", i), vecs[i].isD ? ifA.d_stall : ifA.i_stall, 1);
            step();
            check($sformatf("v%0d_mem_req", i),  ifA.mem_req,  1);
            check($sformatf("v%0d_mem_addr", i), ifA.mem_addr, vecs[i].addr);
            check($sformatf("v%0d_mem_we", i),   ifA.mem_we,   vecs[i].isD & vecs[i].we);
            if (vecs[i].isD && vecs[i].we)
                check($sformatf("v%0d_mem_wdata", i), ifA.mem_wdata, vecs[i].wdata);
            for (int k = 0; k < vecs[i].ackDelay; k++) begin
                check($sformatf("v%0d_wait_stall", i), vecs[i].isD ? ifA.d_stall : ifA.i_stall, 1);
                step();
            end
            ifA.mem_ack = 1'b1;
            ifA.mem_rdata = vecs[i].rdata;
            qA.push_back('{vecs[i].isD, vecs[i].expRdata});
            step();
            ifA.mem_ack = 1'b0;
            ifA.mem_rdata = 32'h0BAD_0BAD;
            check($sformatf("v%0d_done", i),  vecs[i].isD ? ifA.d_done : ifA.i_done, 1);
            check($sformatf("v%0d_stall_resp", i), vecs[i].isD ? ifA.d_stall : ifA.i_stall, 0);
            check($sformatf("v%0d_req_low", i), ifA.mem_req, 0);
            ifA.i_req = 1'b0;
            ifA.d_req = 1'b0;
            step();
            check($sformatf("v%0d_done_gone", i), {ifA.i_done, ifA.d_done}, 0);
        end
        check("A_no_err_at_boundary_ack", ifA.bus_err, 0);

        // Simultaneous requests, data priority: D write first, then I
        ifA.i_req = 1'b1; ifA.i_addr = 32'h0000_0044;
        ifA.d_req = 1'b1; ifA.d_we = 1'b1;
        ifA.d_addr = 32'h0000_0100; ifA.d_wdata = 32'hDEAD_BEEF;
        step();
        check("prio_first_addr",  ifA.mem_addr,  32'h0000_0100);
        check("prio_first_we",    ifA.mem_we,    1);
        check("prio_first_wdata", ifA.mem_wdata, 32'hDEAD_BEEF);
        ifA.mem_ack = 1'b1;
        ifA.mem_rdata = 32'h1111_1111;
        qA.push_back('{1'b1, 32'h0000_00A5});
        step();
        ifA.mem_ack = 1'b0;
        check("prio_d_done",      ifA.d_done,  1);
        check("prio_i_stall_1",   ifA.i_stall, 1);
        ifA.d_req = 1'b0;
        step();
        check("prio_gap_req",     ifA.mem_req, 0);
        check("prio_i_stall_2",   ifA.i_stall, 1);
        step();
        check("prio_second_addr", ifA.mem_addr, 32'h0000_0044);
        check("prio_second_we",   ifA.mem_we,   0);
        check("prio_i_stall_3",   ifA.i_stall,  1);
        ifA.mem_ack = 1'b1;
        ifA.mem_rdata = 32'h0800_0010;
        qA.push_back('{1'b0, 32'h0800_0010});
        step();
        ifA.mem_ack = 1'b0;
        check("prio_i_done",      ifA.i_done,  1);
        check("prio_i_stall_4",   ifA.i_stall, 0);
        ifA.i_req = 1'b0;
        step();

        // Timeout: D read, never acked
        ifA.d_req = 1'b1; ifA.d_we = 1'b0; ifA.d_addr = 32'h0000_0300;
        qA.push_back('{1'b1, 32'h0});
        step();
        hi = 0;
        for (int c = 0; c < 10 && ifA.mem_req; c++) begin
            hi++;
            step();
        end
        check("to_req_cycles", hi, 4);
        check("to_d_done",     ifA.d_done,  1);
        check("to_bus_err",    ifA.bus_err, 1);
        ifA.d_req = 1'b0;
        ifA.mem_ack = 1'b1;
        ifA.mem_rdata = 32'h9999_9999;
        step();
        check("to_late_ack_req",  ifA.mem_req, 0);
        check("to_late_ack_done", {ifA.i_done, ifA.d_done}, 0);
        step();
        ifA.mem_ack = 1'b0;
        check("to_late_ack_done2", {ifA.i_done, ifA.d_done}, 0);
        check("to_err_sticky",     ifA.bus_err, 1);

        // Reset during DBUS, then a fresh grant with a stale ack in IDLE
        ifA.d_req = 1'b1; ifA.d_we = 1'b0; ifA.d_addr = 32'h0000_0400;
        step();
        check("rst_pre_req", ifA.mem_req, 1);
        #2;
        rstA = 1'b0;
        #1;
        check("rst_mid_req",    ifA.mem_req, 0);
        check("rst_mid_done",   ifA.d_done,  0);
        check("rst_mid_err",    ifA.bus_err, 0);
        check("rst_mid_rdata",  ifA.d_rdata, 0);
        step();
        rstA = 1'b1;
        ifA.mem_ack = 1'b1;
        ifA.mem_rdata = 32'h3333_3333;
        #1;
        check("rst_idle_stall", ifA.d_stall, 1);
        step();
        ifA.mem_ack = 1'b0;
        check("rst_regrant_req",  ifA.mem_req,  1);
        check("rst_regrant_addr", ifA.mem_addr, 32'h0000_0400);
        check("rst_stale_done",   ifA.d_done,   0);
        step();
        check("rst_still_bus",    ifA.mem_req,  1);
        ifA.mem_ack = 1'b1;
        ifA.mem_rdata = 32'h7777_0000;
        qA.push_back('{1'b1, 32'h7777_0000});
        step();
        ifA.mem_ack = 1'b0;
        check("rst_done", ifA.d_done, 1);
        ifA.d_req = 1'b0;
        step();

        // Round-robin on B: grants alternate D,I,D,I with an idle gap
        ifB.i_req = 1'b1; ifB.i_addr = 32'h0000_0010;
        ifB.d_req = 1'b1; ifB.d_we = 1'b0; ifB.d_addr = 32'h0000_0020;
        for (int t = 0; t < 4; t++) begin
            isD = (t % 2 == 0);
            step();
            check($sformatf("rr%0d_req", t),  ifB.mem_req, 1);
            check($sformatf("rr%0d_addr", t), ifB.mem_addr, isD ? 32'h0000_0020 : 32'h0000_0010);
            ifB.mem_ack = 1'b1;
            ifB.mem_rdata = 32'hB000_0000 | t;
            qB.push_back('{isD, 32'hB000_0000 | t});
            step();
            ifB.mem_ack = 1'b0;
            check($sformatf("rr%0d_done", t), isD ? ifB.d_done : ifB.i_done, 1);
            check($sformatf("rr%0d_other_stall", t), isD ? ifB.i_stall : ifB.d_stall, 1);
            if (t == 3) begin
                ifB.i_req = 1'b0;
                ifB.d_req = 1'b0;
            end
            step();
            check($sformatf("rr%0d_gap", t), ifB.mem_req, 0);
        end

        // Dropped request on B: I transaction still completes
        ifB.i_req = 1'b1; ifB.i_addr = 32'h0000_0080;
        step();
        check("drop_addr", ifB.mem_addr, 32'h0000_0080);
        ifB.i_req = 1'b0;
        step();
        step();
        step();
        check("drop_wait_req", ifB.mem_req, 1);
        ifB.mem_ack = 1'b1;
        ifB.mem_rdata = 32'h1234_5678;
        qB.push_back('{1'b0, 32'h1234_5678});
        step();
        ifB.mem_ack = 1'b0;
        check("drop_i_done", ifB.i_done, 1);
        check("drop_stall",  ifB.i_stall, 0);
        step();
        step();

        check("qA_drained", qA.size(), 0);
        check("qB_drained", qB.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates one shared single-port memory bus between the fetch-stage instruction port and the mem-stage data port of the 5-stage MIPS pipeline. Runs one transaction at a time over a req/ack bus with variable latency. Stalls the losing or waiting requester, and latches read data for the pipeline registers. Sits between the datapath (pcF/instrF and aluoutM/writedataM/readdataM) and the memory controller.

Parameters:
AW, 32, address width
DW, 32, data width
DATA_PRIO, 1, 1 = data port has strict priority; 0 = round-robin on last grant
TIMEOUT, 16, max cycles waiting for mem_ack; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
i_req  in  1  instruction fetch request (level)
i_addr  in  AW  fetch address (pcF)
i_rdata  out  DW  fetched instruction, valid while i_done=1, then held
i_done  out  1  one-cycle completion pulse for the I transaction
i_stall  out  1  stall for fetch/decode
d_req  in  1  data access request (level)
d_we  in  1  1 = write, 0 = read
d_addr  in  AW  data address (aluoutM)
d_wdata  in  DW  store data (writedataM)
d_rdata  out  DW  load data, valid while d_done=1, then held
d_done  out  1  one-cycle completion pulse for the D transaction
d_stall  out  1  stall for the mem stage and everything upstream
mem_req  out  1  bus request, held until ack or timeout
mem_we  out  1  bus write enable
mem_addr  out  AW  bus address
mem_wdata  out  DW  bus write data
mem_rdata  in  DW  bus read data, sampled in the mem_ack cycle
mem_ack  in  1  bus completion, one cycle
bus_err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, i/d_rdata, i/d_done and bus_err. last_grant=I. Timeout counter=0.
- Reset mid-transaction: mem_req drops immediately. A late mem_ack arriving after reset is ignored.
- States: IDLE, IBUS, DBUS, IRESP, DRESP.
- IDLE:
  - If only one request is pending, grant that requester.
  - If both are pending and DATA_PRIO=1, grant D.
  - If both are pending and DATA_PRIO=0, grant the requester opposite to last_grant.
  - At the grant edge, latch addr (plus we/wdata for D) into the bus registers, move to IBUS/DBUS, and update last_grant.
- IBUS/DBUS:
  - mem_req=1 and the bus fields are stable.
  - Requester inputs are ignored after the grant edge.
  - On mem_ack: capture mem_rdata into i_rdata (IBUS) or d_rdata (DBUS read only). Clear mem_req at the same edge and go to IRESP/DRESP.
  - A D write never updates d_rdata.
- Timeout: the counter increments each cycle in IBUS/DBUS without ack. When it reaches TIMEOUT-1 with no ack:
  - drop mem_req, set bus_err=1, and go to RESP;
  - the read data register loads 0 (reads as a NOP for I).
  - mem_ack in that same cycle wins over the timeout.
- IRESP/DRESP: i_done or d_done=1 for exactly one cycle, then return to IDLE. There is no bus issue in RESP, so back-to-back transactions cost one idle cycle.
- Latency: if req is seen high at edge N, mem_req is high from cycle N+1. If ack arrives in cycle N+1+k (k≥0), done is high in cycle N+2+k. Minimum is 3 cycles from request to done.
- Stalls (combinational from state and req only, with no path from mem_ack):
  - i_stall = i_req & ~(state==IRESP)
  - d_stall = d_req & ~(state==DRESP)
- Requester drops req mid-transaction: the transaction completes and the done pulse is still generated. A write is never cancelled.
- mem_ack in IDLE or RESP: ignored.
- bus_err is cleared only by reset.

Decomposition:
- Shared header arb_defines.vh holds the state encodings (3-bit localparams) and the grant encodings (GNT_I=0, GNT_D=1).
- No sub-module. The timeout counter is inline, with width $clog2(TIMEOUT+1).
- Built with the codebase's existing flopr/flopenr-style registers.

Test Plan:
- I read only: i_req=1, i_addr=0x0000_0040, ack after 2 cycles with mem_rdata=0x2008_0005 -> mem_addr=0x40, mem_we=0; i_done pulses 1 cycle later with i_rdata=0x2008_0005; i_stall low only in that cycle.
- Simultaneous requests with DATA_PRIO=1: i_req=d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, ack immediately each time -> D is served first (mem_we=1, mem_wdata=0xDEAD_BEEF), I second; i_stall stays high through both transactions.
- Round-robin with DATA_PRIO=0: both requests held for 4 transactions -> grant order D,I,D,I after reset, with a one-cycle IDLE gap between them.
- Timeout with TIMEOUT=4: d_req read with no ack -> mem_req high for 4 cycles then low; d_done pulses with d_rdata=0 and bus_err=1; a later ack is ignored.
- Reset mid-transaction: rst=0 during DBUS -> mem_req=0 and d_done=0 immediately; after release, with d_req still high, a fresh grant occurs and a stale ack during IDLE is ignored.
- Request dropped: i_req deasserted one cycle after grant, ack after 3 cycles with mem_rdata=0x1234_5678 -> i_done still pulses and i_rdata=0x1234_5678.
